updown_counter: RTL and testbench
=================================

# updown_counter

Parametrised successor to the free-running N-bit incrementer: a loadable up/down counter with programmable step, programmable modulus, and a runtime wrap/saturate mode. Boundary crossings are reported as a one-cycle event pulse and a sticky flag. Used for pipeline cycle/instruction counters, modulo address generators and timeout timers. All state is registered; count is observed directly from the register.

## Interface
- WIDTH, 32, counter width in bits.
- INIT, 0, reset value of count; must satisfy INIT <= MAX_VAL.
- MAX_VAL, 2^WIDTH-1, largest legal count; the modulus is MAX_VAL+1.

Ports (clock and reset first):
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-low.
- en  in  1  advance count by step this cycle.
- up  in  1  1 = count up, 0 = count down.
- sat  in  1  1 = saturate at 0/MAX_VAL, 0 = wrap modulo MAX_VAL+1.
- step  in  WIDTH  increment magnitude; values > MAX_VAL are clamped to MAX_VAL.
- load  in  1  synchronous load of load_val; priority over en.
- load_val  in  WIDTH  load value; values > MAX_VAL are clamped to MAX_VAL.
- clr_sticky  in  1  clear evt_sticky.
- count  out  WIDTH  current count (register output).
- evt  out  1  registered pulse: the previous update crossed a boundary.
- evt_sticky  out  1  set by any boundary crossing; held until clr_sticky.
- at_max  out  1  combinational: count == MAX_VAL.
- at_zero  out  1  combinational: count == 0.

## Operation
- Reset (rst low, async): count = INIT, evt = 0, evt_sticky = 0. Outputs hold reset values while rst is low; the first update takes effect on the first posedge after rst rises.
- Per-cycle priority: load > en > hold.
- load = 1: count <= min(load_val, MAX_VAL); evt <= 0; no sticky set. up, sat, step and en are ignored.
- en = 1, load = 0: let s = min(step, MAX_VAL).
  - Compute in WIDTH+1 bits; no intermediate truncation.
  - Up, count+s <= MAX_VAL: count <= count+s, no event.
  - Up, count+s > MAX_VAL (overflow): wrap mode gives count <= count+s-(MAX_VAL+1); sat mode gives count <= MAX_VAL.
  - Down, s <= count: count <= count-s, no event.
  - Down, s > count (underflow): wrap mode gives count <= count+(MAX_VAL+1)-s; sat mode gives count <= 0.
  - On an overflow/underflow: evt <= 1 and evt_sticky <= 1. An event fires in sat mode too, including when count is already pinned at the limit.
  - s = 0: count holds, no event.
- en = 0, load = 0: count holds; evt <= 0.
- evt is 1 for exactly one cycle per crossing. Crossings on consecutive cycles keep evt high on consecutive cycles.
- evt_sticky: a set in the same cycle as clr_sticky wins (flag stays 1). clr_sticky alone clears it on the next edge. load does not affect it.
- up, sat and step may change on any cycle; each cycle uses the values sampled at that edge.

## Timing
- Latency: count, evt and evt_sticky update on the posedge that samples the controls. The new value is visible after that edge, 1 cycle after the inputs.
- at_max/at_zero follow count combinationally, with no extra latency.
- Reset mid-operation: immediate, asynchronous return to reset values. Any in-flight evt pulse is dropped.
- Throughput: one update per cycle, no stalls, no handshake.
- Critical path: one WIDTH+1-bit add/subtract, one compare against MAX_VAL+1, and a 4:1 select.

## Test plan
Bench configuration: WIDTH=8, MAX_VAL=9, INIT=0 unless noted.
- Reset: hold rst low with en=1 -> count=0, evt=0, evt_sticky=0, at_zero=1. Release rst -> first increment appears after the next posedge.
- Wrap up: en=1, up=1, sat=0, step=1 for 12 cycles from 0 -> count 1..9,0,1,2. evt high only in the cycle count shows 0. at_max high while count=9. evt_sticky=1 afterwards.
- Wrap down with step: load 2, then en=1, up=0, step=3 -> 9 (evt=1), then 6, then 3 (evt=0). step=15 is clamped to 9, so from 3 the count goes to 4 with evt=1.
- Saturate: sat=1, up=1, step=4 from 7 -> 9 (evt=1), 9 (evt=1 again). Switch up=0, step=5 -> 4, then 0 (evt=1).
- Priority and sticky: load=1, en=1, load_val=200 -> count=9, evt=0. Drive clr_sticky=1 in the same cycle as an overflow -> evt_sticky stays 1. clr_sticky alone on the next cycle -> evt_sticky=0.
- Async reset mid-count: with count=5 and evt=1, pulse rst low between edges -> count=0 and evt=0 immediately, without waiting for an edge. INIT=7 variant -> count=7 after reset.

Source files
------------

// File: rtl/updown_counter.sv
// Loadable up/down counter with a clamped step, a programmable modulus and a wrap/saturate mode.
// Boundary crossings raise a one-cycle evt pulse and a sticky flag that stays set until cleared.
module updown_counter #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] INIT    = '0,
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_sticky,
    output logic [WIDTH-1:0] count,
    output logic             evt,
    output logic             evt_sticky,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH:0] ONE_W   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] MAX_W   = {1'b0, MAX_VAL};
    localparam logic [WIDTH:0] MODULUS = MAX_W + ONE_W;

    logic [WIDTH-1:0] count_reg, count_next;
    logic             evt_reg, evt_next;
    logic             sticky_reg, sticky_next;

    logic [WIDTH-1:0] step_clamped;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrapped;
    logic [WIDTH:0]   down_diff;
    logic [WIDTH:0]   down_wrapped;
    logic             overflow;
    logic             underflow;
    logic             crossing;

    // All arithmetic is done one bit wider so the modulus and the carry are never truncated.
    always_comb begin
        step_clamped = (step > MAX_VAL) ? MAX_VAL : step;
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        up_sum       = {1'b0, count_reg} + {1'b0, step_clamped};
        up_wrapped   = up_sum - MODULUS;
        down_diff    = {1'b0, count_reg} - {1'b0, step_clamped};
        down_wrapped = {1'b0, count_reg} + MODULUS - {1'b0, step_clamped};
        overflow     = (up_sum > MAX_W);
        underflow    = (step_clamped > count_reg);
    end

    always_comb begin
        count_next = count_reg;
        crossing   = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (en) begin
            if (up) begin
                if (overflow) begin
                    crossing   = 1'b1;
                    count_next = sat ? MAX_VAL : up_wrapped[WIDTH-1:0];
                end else begin
                    count_next = up_sum[WIDTH-1:0];
                end
            end else begin
                if (underflow) begin
                    crossing   = 1'b1;
                    count_next = sat ? '0 : down_wrapped[WIDTH-1:0];
                end else begin
                    count_next = down_diff[WIDTH-1:0];
                end
            end
        end
        evt_next    = crossing;
        // A crossing in the same cycle as a clear keeps the flag set.
        sticky_next = crossing | (sticky_reg & ~clr_sticky);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg  <= INIT;
            evt_reg    <= 1'b0;
            sticky_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            evt_reg    <= evt_next;
            sticky_reg <= sticky_next;
        end
    end

    assign count      = count_reg;
    assign evt        = evt_reg;
    assign evt_sticky = sticky_reg;
    assign at_max     = (count_reg == MAX_VAL);
    assign at_zero    = (count_reg == '0);

endmodule

// File: tb/tb_updown_counter.sv
// Directed and randomized checks of updown_counter (WIDTH=8, MAX_VAL=9) against an integer model.
module tb_updown_counter;

    localparam int M = 9;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, up, sat, load, clr_sticky;
    logic [7:0] step, load_val;
    logic [7:0] count, count7;
    logic       evt, evt_sticky, at_max, at_zero;
    logic       evt7, evt_sticky7, at_max7, at_zero7;

    int total = 0;
    int bad   = 0;
    int m_count;
    bit m_evt, m_sticky;

    updown_counter #(.WIDTH(8), .INIT(8'd0), .MAX_VAL(8'd9)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .step(step),
        .load(load), .load_val(load_val), .clr_sticky(clr_sticky),
        .count(count), .evt(evt), .evt_sticky(evt_sticky),
        .at_max(at_max), .at_zero(at_zero)
    );

    updown_counter #(.WIDTH(8), .INIT(8'd7), .MAX_VAL(8'd9)) dut_init7 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .step(step),
        .load(load), .load_val(load_val), .clr_sticky(clr_sticky),
        .count(count7), .evt(evt7), .evt_sticky(evt_sticky7),
        .at_max(at_max7), .at_zero(at_zero7)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predict the next state from the rules in integer arithmetic, clock once, then compare.
    task automatic step_cycle(input string tag);
        int s, t;
        bit crossing;
        crossing = 1'b0;
        t = m_count;
        if (load) begin
            t = (int'(load_val) > M) ? M : int'(load_val);
        end else if (en) begin
            s = (int'(step) > M) ? M : int'(step);
            if (up) begin
                t = m_count + s;
                if (t > M) begin
                    crossing = 1'b1;
                    t = sat ? M : t - (M + 1);
                end
            end else begin
                t = m_count - s;
                if (t < 0) begin
                    crossing = 1'b1;
                    t = sat ? 0 : t + (M + 1);
                end
            end
        end
        @(posedge clk);
        #1;
        m_sticky = crossing | (m_sticky & !clr_sticky);
        m_count  = t;
        m_evt    = crossing;
        check({tag, ".count"},   32'(count),      32'(m_count));
        check({tag, ".evt"},     32'(evt),        32'(m_evt));
        check({tag, ".sticky"},  32'(evt_sticky), 32'(m_sticky));
        check({tag, ".at_max"},  32'(at_max),     32'(m_count == M));
        check({tag, ".at_zero"}, 32'(at_zero),    32'(m_count == 0));
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0; step = 8'd1;
        load = 1'b0; load_val = 8'd0; clr_sticky = 1'b0;
        m_count = 0; m_evt = 1'b0; m_sticky = 1'b0;

        // Reset held with en=1: outputs stay at reset values across edges.
        #2;
        check("rst_pre.count", 32'(count), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst.count",   32'(count),      32'd0);
        check("rst.evt",     32'(evt),        32'd0);
        check("rst.sticky",  32'(evt_sticky), 32'd0);
        check("rst.at_zero", 32'(at_zero),    32'd1);
        check("rst.init7",   32'(count7),     32'd7);
        @(negedge clk);
        rst = 1'b1;

        // Wrap up, step 1, twelve cycles.
        for (int i = 0; i < 12; i++) step_cycle("wrap_up");
        check("wrap_up.final",  32'(count),      32'd2);
        check("wrap_up.sticky", 32'(evt_sticky), 32'd1);

        // Wrap down with step 3, then a clamped step of 15.
        load = 1'b1; load_val = 8'd2;
        step_cycle("load2");
        load = 1'b0; up = 1'b0; step = 8'd3;
        step_cycle("wrap_dn");
        check("wrap_dn.first", 32'(count), 32'd9);
        step_cycle("wrap_dn");
        step_cycle("wrap_dn");
        check("wrap_dn.three", 32'(count), 32'd3);
        step = 8'd15;
        step_cycle("clamp_step");
        check("clamp_step.count", 32'(count), 32'd4);
        check("clamp_step.evt",   32'(evt),   32'd1);

        // Saturate up then down, including the event while already pinned.
        load = 1'b1; load_val = 8'd7;
        step_cycle("load7");
        load = 1'b0; sat = 1'b1; up = 1'b1; step = 8'd4;
        step_cycle("sat_up");
        step_cycle("sat_up_pinned");
        check("sat_up.count", 32'(count), 32'd9);
        check("sat_up.evt",   32'(evt),   32'd1);
        up = 1'b0; step = 8'd5;
        step_cycle("sat_dn");
        step_cycle("sat_dn");
        check("sat_dn.count", 32'(count), 32'd0);
        check("sat_dn.evt",   32'(evt),   32'd1);

        // Load beats enable; sticky set beats clear.
        load = 1'b1; en = 1'b1; load_val = 8'd200;
        step_cycle("prio_load");
        check("prio_load.count", 32'(count), 32'd9);
        load = 1'b0; up = 1'b1; sat = 1'b0; step = 8'd1; clr_sticky = 1'b1;
        step_cycle("clr_vs_set");
        check("clr_vs_set.sticky", 32'(evt_sticky), 32'd1);
        en = 1'b0;
        step_cycle("clr_alone");
        check("clr_alone.sticky", 32'(evt_sticky), 32'd0);
        clr_sticky = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            load       = ($urandom_range(0, 7) == 0);
            en         = ($urandom_range(0, 3) != 0);
            up         = 1'($urandom);
            sat        = 1'($urandom);
            step       = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            load_val   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 11));
            clr_sticky = ($urandom_range(0, 7) == 0);
            step_cycle("rand");
        end

        // Asynchronous reset between edges while evt is high.
        load = 1'b1; load_val = 8'd9; clr_sticky = 1'b0;
        step_cycle("pre_arst");
        load = 1'b0; en = 1'b1; up = 1'b1; sat = 1'b0; step = 8'd6;
        step_cycle("pre_arst");
        check("pre_arst.count", 32'(count), 32'd5);
        check("pre_arst.evt",   32'(evt),   32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("arst.count",   32'(count),      32'd0);
        check("arst.evt",     32'(evt),        32'd0);
        check("arst.sticky",  32'(evt_sticky), 32'd0);
        check("arst.at_zero", 32'(at_zero),    32'd1);
        check("arst.init7",   32'(count7),     32'd7);
        @(negedge clk);
        rst = 1'b1;
        m_count = 0; m_evt = 1'b0; m_sticky = 1'b0;
        step = 8'd1;
        step_cycle("post_arst");
        check("post_arst.count", 32'(count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
